// File: rtl/dp_ram_pkg.sv
// Shared defaults and helpers for the valid-tracked dual-port RAM.
// Pure constants/types, no timing or flow control.
package dp_ram_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  // Address width for a given depth, never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Which register currently drives rd_data.
  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_CORE = 2'd1,
    SRC_BYP  = 2'd2
  } rd_src_e;

endpackage

// File: rtl/dp_ram_core.sv
// Plain simple dual-port array with a registered read port, read-first on collision.
// One-cycle read latency; no backpressure, output register holds when rd_en_i is low.
module dp_ram_core
  import dp_ram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/dp_ram_param.sv
// Dual-port RAM with per-entry valid bits, collision bypass, error pulses and occupancy count.
// One-cycle read latency; no backpressure, errors are flagged and the request dropped.
module dp_ram_param
  import dp_ram_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int ADDR_W      = addr_w(DEPTH),
  parameter bit CLR_ON_READ = 1'b1,
  parameter bit BYPASS      = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  output logic              wr_err,
  output logic              ovwr,
  output logic [ADDR_W:0]   count
);

  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_err_q, rd_err_d;
  logic              wr_err_q, wr_err_d;
  logic              ovwr_q, ovwr_d;
  logic [DATA_W-1:0] byp_q;
  rd_src_e           src_q;
  logic [DATA_W-1:0] core_rdata;

  logic wr_ok, rd_ok, coll, byp_hit, rd_hit, core_re, set_new, clr_old;

  always_comb begin
    wr_ok   = wr_en && (int'(wr_addr) < DEPTH);
    rd_ok   = rd_en && (int'(rd_addr) < DEPTH);
    coll    = wr_ok && rd_ok && (wr_addr == rd_addr);
    byp_hit = BYPASS && coll;
    rd_hit  = rd_ok && (byp_hit || vld_q[rd_addr]);
    core_re = rd_ok && vld_q[rd_addr] && !byp_hit;

    // Order of set/clear decides who wins on a same-address collision.
    vld_d = vld_q;
    if (BYPASS) begin
      if (wr_ok) vld_d[wr_addr] = 1'b1;
      if (CLR_ON_READ && rd_hit) vld_d[rd_addr] = 1'b0;
    end else begin
      if (CLR_ON_READ && rd_hit) vld_d[rd_addr] = 1'b0;
      if (wr_ok) vld_d[wr_addr] = 1'b1;
    end

    set_new = wr_ok && !vld_q[wr_addr] && vld_d[wr_addr];
    clr_old = rd_ok && vld_q[rd_addr] && !vld_d[rd_addr];
    count_d = count_q + (ADDR_W+1)'(set_new) - (ADDR_W+1)'(clr_old);

    rd_valid_d = rd_hit;
    rd_err_d   = rd_en && !rd_hit;
    wr_err_d   = wr_en && !wr_ok;
    ovwr_d     = wr_ok && vld_q[wr_addr] && !byp_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q      <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      wr_err_q   <= 1'b0;
      ovwr_q     <= 1'b0;
      byp_q      <= '0;
      src_q      <= SRC_ZERO;
    end else begin
      vld_q      <= vld_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      wr_err_q   <= wr_err_d;
      ovwr_q     <= ovwr_d;
      // rd_data keeps following the last successful read source.
      if (byp_hit) begin
        byp_q <= wr_data;
        src_q <= SRC_BYP;
      end else if (core_re) begin
        src_q <= SRC_CORE;
      end
    end
  end

  dp_ram_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk       (clk),
    .wr_en_i   (wr_ok && !rst),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_en_i   (core_re && !rst),
    .rd_addr_i (rd_addr),
    .rd_data_o (core_rdata)
  );

  always_comb begin
    case (src_q)
      SRC_CORE: rd_data = core_rdata;
      SRC_BYP:  rd_data = byp_q;
      default:  rd_data = '0;
    endcase
  end

  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;
  assign wr_err   = wr_err_q;
  assign ovwr     = ovwr_q;
  assign count    = count_q;

endmodule

// File: tb/tb_dp_ram_param.sv
// Four configurations of dp_ram_param driven in lockstep and compared each cycle
// against an entry-level reference model, plus literal scenario checks.
module tb_dp_ram_param;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0, rd_en = 1'b0;
  logic [3:0] wa = '0, ra = '0;
  logic [7:0] wd = '0;

  logic [7:0] rdd [N];
  logic       rdv [N];
  logic       rde [N];
  logic       wre [N];
  logic       ovw [N];
  logic [4:0] cnt [N];

  int checks = 0;
  int errors = 0;

  int       mem_m [N][16];
  bit       vld_m [N][16];
  int       e_rdd [N];
  bit       e_rdv [N];
  bit       e_rde [N];
  bit       e_wre [N];
  bit       e_ovw [N];
  int       e_cnt [N];

  always #5 clk = ~clk;

  dp_ram_param #(.DATA_W(8), .DEPTH(16), .CLR_ON_READ(1), .BYPASS(1)) u_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wa), .wr_data(wd), .rd_en(rd_en), .rd_addr(ra),
    .rd_data(rdd[0]), .rd_valid(rdv[0]), .rd_err(rde[0]), .wr_err(wre[0]), .ovwr(ovw[0]), .count(cnt[0]));
  dp_ram_param #(.DATA_W(8), .DEPTH(16), .CLR_ON_READ(1), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wa), .wr_data(wd), .rd_en(rd_en), .rd_addr(ra),
    .rd_data(rdd[1]), .rd_valid(rdv[1]), .rd_err(rde[1]), .wr_err(wre[1]), .ovwr(ovw[1]), .count(cnt[1]));
  dp_ram_param #(.DATA_W(8), .DEPTH(12), .CLR_ON_READ(1), .BYPASS(1)) u_c (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wa), .wr_data(wd), .rd_en(rd_en), .rd_addr(ra),
    .rd_data(rdd[2]), .rd_valid(rdv[2]), .rd_err(rde[2]), .wr_err(wre[2]), .ovwr(ovw[2]), .count(cnt[2]));
  dp_ram_param #(.DATA_W(8), .DEPTH(10), .CLR_ON_READ(0), .BYPASS(0)) u_d (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wa), .wr_data(wd), .rd_en(rd_en), .rd_addr(ra),
    .rd_data(rdd[3]), .rd_valid(rdv[3]), .rd_err(rde[3]), .wr_err(wre[3]), .ovwr(ovw[3]), .count(cnt[3]));

  function automatic int dep(input int i);
    case (i)
      2:       return 12;
      3:       return 10;
      default: return 16;
    endcase
  endfunction

  function automatic bit clr(input int i);
    return (i != 3);
  endfunction

  function automatic bit byp(input int i);
    return (i == 0 || i == 2);
  endfunction

  task automatic chk(input string nm, input int i, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d got=%0h expected=%0h at %0t", nm, i, act, exp, $time);
    end
  endtask

  // Entry-level model of one clock edge, using the inputs as they stand.
  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      bit wok, rok, coll;
      if (rst) begin
        for (int j = 0; j < 16; j++) vld_m[i][j] = 1'b0;
        e_rdd[i] = 0; e_rdv[i] = 0; e_rde[i] = 0; e_wre[i] = 0; e_ovw[i] = 0;
      end else begin
        wok  = wr_en && (int'(wa) < dep(i));
        rok  = rd_en && (int'(ra) < dep(i));
        coll = wok && rok && (wa == ra);
        e_wre[i] = wr_en && !wok;
        e_ovw[i] = wok && vld_m[i][wa] && !(coll && byp(i));
        e_rdv[i] = 0;
        e_rde[i] = 0;
        if (rd_en && !rok) e_rde[i] = 1;
        else if (rok) begin
          if (coll && byp(i)) begin
            e_rdv[i] = 1; e_rdd[i] = int'(wd);
          end else if (vld_m[i][ra]) begin
            e_rdv[i] = 1; e_rdd[i] = mem_m[i][ra];
          end else e_rde[i] = 1;
        end
        if (rok && !coll && vld_m[i][ra] && clr(i)) vld_m[i][ra] = 1'b0;
        if (wok) begin
          mem_m[i][wa] = int'(wd);
          vld_m[i][wa] = !(coll && byp(i) && clr(i));
        end
      end
      e_cnt[i] = 0;
      for (int j = 0; j < 16; j++) e_cnt[i] += int'(vld_m[i][j]);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk("rd_data",  i, int'(rdd[i]), e_rdd[i]);
      chk("rd_valid", i, int'(rdv[i]), int'(e_rdv[i]));
      chk("rd_err",   i, int'(rde[i]), int'(e_rde[i]));
      chk("wr_err",   i, int'(wre[i]), int'(e_wre[i]));
      chk("ovwr",     i, int'(ovw[i]), int'(e_ovw[i]));
      chk("count",    i, int'(cnt[i]), e_cnt[i]);
    end
  endtask

  task automatic drive(input bit we, input int a_w, input int d, input bit re, input int a_r);
    wr_en = we; wa = 4'(a_w); wd = 8'(d); rd_en = re; ra = 4'(a_r);
    cyc();
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic reset_cycle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    cyc();
    cyc();
    rst = 1'b0;
    chk("lit_rst_count", 0, int'(cnt[0]), 0);
    chk("lit_rst_rdv",   0, int'(rdv[0]), 0);
    chk("lit_rst_rdd",   0, int'(rdd[0]), 0);

    // Write then consume one entry.
    drive(1, 3, 8'hA5, 0, 0);
    chk("lit_wr3_count", 0, int'(cnt[0]), 1);
    drive(0, 0, 0, 1, 3);
    chk("lit_rd3_data",  0, int'(rdd[0]), 8'hA5);
    chk("lit_rd3_vld",   0, int'(rdv[0]), 1);
    chk("lit_rd3_count", 0, int'(cnt[0]), 0);
    chk("lit_rd3_keep",  3, int'(cnt[3]), 1);

    // Read of an empty entry holds previous data.
    drive(0, 0, 0, 1, 7);
    chk("lit_rd7_err",  0, int'(rde[0]), 1);
    chk("lit_rd7_vld",  0, int'(rdv[0]), 0);
    chk("lit_rd7_data", 0, int'(rdd[0]), 8'hA5);

    // Fill every address, then overwrite one.
    for (int a = 0; a < 16; a++) drive(1, a, 8'h10 + a, 0, 0);
    chk("lit_fill_count16", 0, int'(cnt[0]), 16);
    chk("lit_fill_count12", 2, int'(cnt[2]), 12);
    chk("lit_fill_count10", 3, int'(cnt[3]), 10);
    drive(1, 0, 8'h77, 0, 0);
    chk("lit_ovwr",       0, int'(ovw[0]), 1);
    chk("lit_ovwr_count", 0, int'(cnt[0]), 16);

    // Same-address collision on an empty entry.
    reset_cycle();
    drive(1, 5, 8'h3C, 1, 5);
    chk("lit_byp_data",   0, int'(rdd[0]), 8'h3C);
    chk("lit_byp_vld",    0, int'(rdv[0]), 1);
    chk("lit_byp_count",  0, int'(cnt[0]), 0);
    chk("lit_rf_err",     1, int'(rde[1]), 1);
    chk("lit_rf_count",   1, int'(cnt[1]), 1);

    // Out-of-range accesses on the 12-deep instance.
    drive(1, 13, 8'h55, 0, 0);
    chk("lit_oor_wr_err", 2, int'(wre[2]), 1);
    chk("lit_oor_count",  2, int'(cnt[2]), 0);
    chk("lit_inr_wr_err", 0, int'(wre[0]), 0);
    drive(0, 0, 0, 1, 13);
    chk("lit_oor_rd_err", 2, int'(rde[2]), 1);

    // Reset landing in the middle of a read burst.
    reset_cycle();
    for (int a = 0; a < 4; a++) drive(1, a, 8'hC0 + a, 0, 0);
    drive(0, 0, 0, 1, 0);
    chk("lit_pre_rst_vld", 0, int'(rdv[0]), 1);
    rst = 1'b1;
    drive(0, 0, 0, 1, 1);
    rst = 1'b0;
    chk("lit_rst_mid_rdd",   0, int'(rdd[0]), 0);
    chk("lit_rst_mid_rdv",   0, int'(rdv[0]), 0);
    chk("lit_rst_mid_rde",   0, int'(rde[0]), 0);
    chk("lit_rst_mid_count", 0, int'(cnt[0]), 0);
    for (int a = 1; a < 4; a++) begin
      drive(0, 0, 0, 1, a);
      chk("lit_post_rst_err", 0, int'(rde[0]), 1);
      chk("lit_post_rst_err", 3, int'(rde[3]), 1);
    end

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 199) == 0);
      wr_en = $urandom_range(0, 1) == 1;
      rd_en = $urandom_range(0, 1) == 1;
      wa    = 4'($urandom_range(0, 15));
      ra    = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      wd    = 8'($urandom);
      cyc();
    end
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dp_ram_param.md
DP_RAM_PARAM -- requirements
Module: dp_ram_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, number of entries (any value 2..1024, not necessarily a power of two).
REQ-003 SHALL have parameter ADDR_W, default $clog2(DEPTH), address width.
REQ-004 SHALL have parameter CLR_ON_READ, default 1: 1 = a read consumes the entry (marks it invalid); 0 = reads are non-destructive.
REQ-005 SHALL have parameter BYPASS, default 1: 1 = write-first on a same-address collision; 0 = read-first.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-008 SHALL have ports wr_en input 1, wr_addr input ADDR_W, and wr_data input DATA_W, which form the write request.
REQ-009 SHALL have ports rd_en input 1 and rd_addr input ADDR_W, which form the read request.
REQ-010 SHALL have port rd_data, output, DATA_W, registered read data.
REQ-011 SHALL have port rd_valid, output, 1, a one-cycle pulse meaning rd_data holds a valid entry.
REQ-012 SHALL have port rd_err, output, 1, a one-cycle pulse for a read of an invalid entry or an out-of-range address.
REQ-013 SHALL have port wr_err, output, 1, a one-cycle pulse for a write to an out-of-range address (addr >= DEPTH).
REQ-014 SHALL have port ovwr, output, 1, a one-cycle pulse for a write to an entry that was already valid.
REQ-015 SHALL have port count, output, ADDR_W+1, the number of currently valid entries.

Function
REQ-016 SHALL keep one valid bit per entry alongside the DEPTH x DATA_W storage array.
REQ-017 SHALL, on an in-range write, store wr_data and set the entry's valid bit at the clock edge.
REQ-018 SHALL register each read request, giving one-cycle read latency: rd_data, rd_valid and rd_err appear the cycle after rd_en.
REQ-019 SHALL, on a valid-entry read, output rd_valid=1 and rd_data=entry, and clear the valid bit if CLR_ON_READ=1.
REQ-020 SHALL, on a read of an invalid entry, output rd_err=1 and rd_valid=0, and hold rd_data at its previous value.
REQ-021 SHALL hold rd_data when rd_en=0, with rd_valid=0 and rd_err=0.
REQ-022 SHALL drop an out-of-range read or write entirely (no state change) and pulse the matching err flag; simulation text messages are not a substitute.
REQ-023 SHALL, on a same-address collision with BYPASS=1: rd_data=wr_data, rd_valid=1; the entry ends invalid if CLR_ON_READ=1, otherwise valid holding wr_data.
REQ-024 SHALL, on a same-address collision with BYPASS=0: return the old contents (rd_valid or rd_err per the old valid bit); the entry ends valid holding wr_data.
REQ-025 SHALL pulse ovwr, with the same timing as rd_valid, when a write hits a previously valid entry; a BYPASS=1 collision does not count as an overwrite.
REQ-026 SHALL update count each cycle as +1 per invalid->valid transition and -1 per valid->invalid transition; the net change is in {-1,0,+1}.
REQ-027 SHALL bound count to 0..DEPTH by construction; no wrap-around is reachable.

Reset
REQ-028 SHALL, while rst=1 at a clock edge, clear all valid bits, rd_data, rd_valid, rd_err, wr_err, ovwr and count to 0.
REQ-029 SHALL give rst priority over any concurrent read or write; an operation started in the cycle before rst still completes its output pulse only if rst is low on the following edge.
REQ-030 SHALL NOT clear the storage array on reset (RAM-inferable); contents are unobservable until rewritten.

Structure
REQ-031 SHALL place shared constants in package dp_ram_pkg: the default DATA_W/DEPTH and the clog2-based width helper.
REQ-032 SHALL contain one sub-module, dp_ram_core: a plain registered-read simple dual-port array with no valid logic; dp_ram_param wraps it with the valid bits, collision muxing, error flags and counter.

Verification
REQ-033 SHALL cover this scenario: after reset, write 0xA5 @3, then read @3 -> next cycle rd_data=0xA5, rd_valid=1, count 1->0 (CLR_ON_READ=1).
REQ-034 SHALL cover this scenario: read @7 never written -> rd_err=1, rd_valid=0, rd_data unchanged, count=0.
REQ-035 SHALL cover this scenario: fill all 16 addresses -> count=16; write @0 again -> ovwr=1, count stays 16.
REQ-036 SHALL cover this scenario: simultaneous write 0x3C and read @5 (empty) -> BYPASS=1 gives rd_data=0x3C, rd_valid=1, count 0; BYPASS=0 gives rd_err=1, count 1.
REQ-037 SHALL cover this scenario: DEPTH=12, write @13 -> wr_err=1, count unchanged; read @13 -> rd_err=1.
REQ-038 SHALL cover this scenario: write 4 entries, assert rst for one cycle mid-read -> all outputs 0; reading those entries afterwards gives rd_err=1.
